processor_controller: RTL

Control unit for the programmable processor. Sequences the PC, instruction register, data memory, register file and ALU through fetch/decode/execute for a 16-bit instruction set of NOOP, STORE, LOAD, ADD, SUB and HALT. State is registered; control outputs are decoded from the current state and the IR fields. `State`/`NextState` are exported for the top-level debug ports.

---
 rtl/processor_pkg.sv | 57 +++++
 rtl/ir_field_decode.sv | 23 ++
 rtl/processor_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared types and constants for the processor control unit: state and
// opcode encodings, ALU select codes and the instruction field layout.
package processor_pkg;

  localparam int IR_W        = 16;
  localparam int OPC_W       = 4;
  localparam int REG_W       = 4;
  localparam int ADDR_W      = 8;

  // Field positions inside the 16-bit instruction word.
  localparam int OPC_LSB     = 12;
  localparam int RA_LSB      = 8;
  localparam int RB_LSB      = 4;
  localparam int RD_LSB      = 0;
  localparam int LD_ADDR_LSB = 4;
  localparam int ST_ADDR_LSB = 0;

  // ALU function codes driven on ALU_s0.
  localparam int ALU_ZERO    = 0;
  localparam int ALU_ADD     = 1;
  localparam int ALU_SUB     = 2;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [OPC_W-1:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  // Execute state entered from Decode; unassigned opcodes run as NOOP.
  function automatic state_t exec_state(opcode_t op);
    case (op)
      OP_STORE: return S_STORE;
      OP_LOAD:  return S_LOAD_A;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_HALT:  return S_HALT;
      default:  return S_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Splits the instruction word into its opcode, register and address fields.
// Every field is extracted unconditionally; the controller picks which ones
// matter for the current state.
module ir_field_decode
  import processor_pkg::*;
(
  input  logic [IR_W-1:0]   ir,
  output opcode_t           opcode,
  output logic [REG_W-1:0]  ra,
  output logic [REG_W-1:0]  rb,
  output logic [REG_W-1:0]  rd,
  output logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] store_addr
);

  assign opcode     = opcode_t'(ir[OPC_LSB +: OPC_W]);
  assign ra         = ir[RA_LSB +: REG_W];
  assign rb         = ir[RB_LSB +: REG_W];
  assign rd         = ir[RD_LSB +: REG_W];
  assign load_addr  = ir[LD_ADDR_LSB +: ADDR_W];
  assign store_addr = ir[ST_ADDR_LSB +: ADDR_W];

endmodule

// File: rtl/processor_controller.sv
// Fetch/decode/execute sequencer for the 16-bit processor. The state is
// registered; all control strobes are decoded from the current state and
// the IR fields, so an asynchronous reset drops write strobes at once.
module processor_controller
  import processor_pkg::*;
#(
  parameter int ALU_SEL_W = 3
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic [IR_W-1:0]      IR,
  output logic                 PC_Clr,
  output logic                 PC_Up,
  output logic                 IR_Ld,
  output logic [ADDR_W-1:0]    D_Addr,
  output logic                 D_Wr,
  output logic                 RF_s,
  output logic [REG_W-1:0]     RF_W_Addr,
  output logic                 RF_W_en,
  output logic [REG_W-1:0]     RF_Ra_Addr,
  output logic [REG_W-1:0]     RF_Rb_Addr,
  output logic [ALU_SEL_W-1:0] ALU_s0,
  output logic [3:0]           State,
  output logic [3:0]           NextState
);

  state_t             state_q;
  state_t             next_state;
  opcode_t            opcode;
  logic [REG_W-1:0]   ra, rb, rd;
  logic [ADDR_W-1:0]  load_addr, store_addr;

  ir_field_decode u_ir_field_decode (
    .ir         (IR),
    .opcode     (opcode),
    .ra         (ra),
    .rb         (rb),
    .rd         (rd),
    .load_addr  (load_addr),
    .store_addr (store_addr)
  );

  // State register; reset forces Init asynchronously.
  always_ff @(posedge Clk or negedge ResetN) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!ResetN) state_q <= S_INIT;
    else         state_q <= next_state;
  end

  // Next-state function of the current state and the opcode only.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no
    // latch is inferred for undecoded states.
    next_state = S_INIT;
    case (state_q)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = exec_state(opcode);
      S_LOAD_A: next_state = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_INIT;
    endcase
  end

  // Control strobe decode; anything not driven by a state stays 0.
  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = ALU_SEL_W'(ALU_ZERO);
    case (state_q)
      S_INIT: PC_Clr = 1'b1;
      S_FETCH: begin
        IR_Ld = 1'b1;
        PC_Up = 1'b1;
      end
      S_DECODE: begin
        // Present read addresses early so register data settles before execute.
        RF_Ra_Addr = ra;
        RF_Rb_Addr = rb;
      end
      S_LOAD_A: begin
        D_Addr = load_addr;
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr    = load_addr;
        RF_s      = 1'b1;
        RF_W_Addr = rd;
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_Addr     = store_addr;
        RF_Ra_Addr = ra;
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = ra;
        RF_Rb_Addr = rb;
        ALU_s0     = (state_q == S_ADD) ? ALU_SEL_W'(ALU_ADD) : ALU_SEL_W'(ALU_SUB);
        RF_W_Addr  = rd;
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State     = state_q;
  assign NextState = next_state;

endmodule
